// File: rtl/lc3_operand_stage_if.sv
// Operand-stage bus: controller-side write-back/decode fields and the ALU operand outputs.
interface lc3_operand_stage_if #(
  parameter int unsigned DATA_SIZE = 16
);
  logic                 ld_reg;
  logic [2:0]           dr;
  logic [DATA_SIZE-1:0] wr_data;
  logic                 ld_cc;
  logic [2:0]           sr1;
  logic [2:0]           sr2;
  logic [4:0]           imm5;
  logic                 sr2mux_sel;
  logic [DATA_SIZE-1:0] op_a;
  logic [DATA_SIZE-1:0] op_b;
  logic [2:0]           nzp;

  modport master (
    output ld_reg, dr, wr_data, ld_cc, sr1, sr2, imm5, sr2mux_sel,
    input  op_a, op_b, nzp
  );

  modport slave (
    input  ld_reg, dr, wr_data, ld_cc, sr1, sr2, imm5, sr2mux_sel,
    output op_a, op_b, nzp
  );
endinterface

// File: rtl/lc3_operand_stage.sv
// LC-3 operand fetch: R0-R7 register file, NZP register, and ALU operand muxing.
module lc3_operand_stage #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned NUM_REGS  = 8,
  parameter bit          BYPASS    = 1'b0
) (
  input logic              clk,
  input logic              rst,
  lc3_operand_stage_if.slave bus
);

  logic [DATA_SIZE-1:0] regs [NUM_REGS];
  logic [2:0]           nzp_q;
  logic [2:0]           cc_next;
  logic [DATA_SIZE-1:0] rd_a;
  logic [DATA_SIZE-1:0] rd_b;
  logic [DATA_SIZE-1:0] imm_ext;

  always_comb begin
    cc_next = 3'b001;
    if (bus.wr_data[DATA_SIZE-1])
      cc_next = 3'b100;
    else if (bus.wr_data == '0)
      cc_next = 3'b010;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      nzp_q <= 3'b010;
    end else begin
      if (bus.ld_reg)
        regs[bus.dr] <= bus.wr_data;
      if (bus.ld_cc)
        nzp_q <= cc_next;
    end
  end

  // Forwarding acts on each register read port separately; the immediate path never forwards.
  always_comb begin
    rd_a = regs[bus.sr1];
    rd_b = regs[bus.sr2];
    if (BYPASS && bus.ld_reg && (bus.dr == bus.sr1))
      rd_a = bus.wr_data;
    if (BYPASS && bus.ld_reg && (bus.dr == bus.sr2))
      rd_b = bus.wr_data;
  end

  assign imm_ext  = {{(DATA_SIZE-5){bus.imm5[4]}}, bus.imm5};
  assign bus.op_a = rd_a;
  assign bus.op_b = bus.sr2mux_sel ? imm_ext : rd_b;
  assign bus.nzp  = nzp_q;

endmodule

// File: tb/tb_lc3_operand_stage.sv
// Directed and model-checked bench; runs a BYPASS=0 and a BYPASS=1 instance on identical stimulus.
module tb_lc3_operand_stage;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  lc3_operand_stage_if #(.DATA_SIZE(16)) bus0 ();
  lc3_operand_stage_if #(.DATA_SIZE(16)) bus1 ();

  assign bus1.ld_reg     = bus0.ld_reg;
  assign bus1.dr         = bus0.dr;
  assign bus1.wr_data    = bus0.wr_data;
  assign bus1.ld_cc      = bus0.ld_cc;
  assign bus1.sr1        = bus0.sr1;
  assign bus1.sr2        = bus0.sr2;
  assign bus1.imm5       = bus0.imm5;
  assign bus1.sr2mux_sel = bus0.sr2mux_sel;

  lc3_operand_stage #(.DATA_SIZE(16), .NUM_REGS(8), .BYPASS(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  lc3_operand_stage #(.DATA_SIZE(16), .NUM_REGS(8), .BYPASS(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus0.ld_reg     = 1'b0;
    bus0.ld_cc      = 1'b0;
    bus0.dr         = 3'd0;
    bus0.wr_data    = 16'h0000;
    bus0.sr1        = 3'd0;
    bus0.sr2        = 3'd0;
    bus0.imm5       = 5'd0;
    bus0.sr2mux_sel = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst          = 1'b1;
    bus0.ld_reg  = 1'b1;
    bus0.ld_cc   = 1'b1;
    bus0.dr      = 3'd4;
    bus0.wr_data = 16'h8001;
    tick();
    rst = 1'b0;
    idle();
    for (int i = 0; i < 8; i++) begin
      bus0.sr1 = 3'(i);
      bus0.sr2 = 3'(7 - i);
      #1;
      n_cmp++;
      if (bus0.op_a !== 16'h0000 || bus1.op_a !== 16'h0000) begin
        n_err++;
        $display("FAIL reset_op_a r%0d got %h/%h want 0000", i, bus0.op_a, bus1.op_a);
      end
      n_cmp++;
      if (bus0.op_b !== 16'h0000 || bus1.op_b !== 16'h0000) begin
        n_err++;
        $display("FAIL reset_op_b r%0d got %h/%h want 0000", 7 - i, bus0.op_b, bus1.op_b);
      end
    end
    n_cmp++;
    if (bus0.nzp !== 3'b010 || bus1.nzp !== 3'b010) begin
      n_err++;
      $display("FAIL reset_nzp got %b/%b want 010", bus0.nzp, bus1.nzp);
    end
  endtask

  task automatic test_write();
    idle();
    bus0.ld_reg  = 1'b1;
    bus0.dr      = 3'd3;
    bus0.wr_data = 16'h1234;
    tick();
    idle();
    bus0.sr1 = 3'd3;
    #1;
    n_cmp++;
    if (bus0.op_a !== 16'h1234 || bus1.op_a !== 16'h1234) begin
      n_err++;
      $display("FAIL write_r3 got %h/%h want 1234", bus0.op_a, bus1.op_a);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 3) continue;
      bus0.sr2 = 3'(i);
      #1;
      n_cmp++;
      if (bus0.op_b !== 16'h0000 || bus1.op_b !== 16'h0000) begin
        n_err++;
        $display("FAIL write_other r%0d got %h/%h want 0000", i, bus0.op_b, bus1.op_b);
      end
    end
  endtask

  task automatic test_imm();
    logic [4:0]  imms [4] = '{5'b10000, 5'b01111, 5'b11111, 5'b00000};
    logic [15:0] exps [4] = '{16'hFFF0, 16'h000F, 16'hFFFF, 16'h0000};
    idle();
    bus0.sr2        = 3'd3;
    bus0.sr2mux_sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus0.imm5 = imms[i];
      #1;
      n_cmp++;
      if (bus0.op_b !== exps[i] || bus1.op_b !== exps[i]) begin
        n_err++;
        $display("FAIL imm_sext imm5=%b got %h/%h want %h", imms[i], bus0.op_b, bus1.op_b, exps[i]);
      end
    end
  endtask

  task automatic test_nzp();
    logic [15:0] wds  [3] = '{16'h8000, 16'h0000, 16'h0001};
    logic [2:0]  exps [3] = '{3'b100, 3'b010, 3'b001};
    idle();
    for (int i = 0; i < 3; i++) begin
      bus0.ld_cc   = 1'b1;
      bus0.wr_data = wds[i];
      tick();
      n_cmp++;
      if (bus0.nzp !== exps[i] || bus1.nzp !== exps[i]) begin
        n_err++;
        $display("FAIL nzp_update wd=%h got %b/%b want %b", wds[i], bus0.nzp, bus1.nzp, exps[i]);
      end
    end
    bus0.ld_cc   = 1'b0;
    bus0.wr_data = 16'h8000;
    tick();
    n_cmp++;
    if (bus0.nzp !== 3'b001 || bus1.nzp !== 3'b001) begin
      n_err++;
      $display("FAIL nzp_hold got %b/%b want 001", bus0.nzp, bus1.nzp);
    end
    // CC update alone must not touch the register file
    bus0.ld_cc = 1'b1;
    bus0.dr    = 3'd3;
    bus0.sr1   = 3'd3;
    tick();
    bus0.ld_cc = 1'b0;
    #1;
    n_cmp++;
    if (bus0.op_a !== 16'h1234 || bus0.nzp !== 3'b100) begin
      n_err++;
      $display("FAIL cc_only got r3=%h nzp=%b want 1234/100", bus0.op_a, bus0.nzp);
    end
  endtask

  task automatic test_bypass();
    idle();
    bus0.ld_reg  = 1'b1;
    bus0.dr      = 3'd5;
    bus0.wr_data = 16'hAAAA;
    tick();
    bus0.wr_data = 16'h5555;
    bus0.sr1     = 3'd5;
    bus0.sr2     = 3'd5;
    #1;
    n_cmp++;
    if (bus0.op_a !== 16'hAAAA || bus0.op_b !== 16'hAAAA) begin
      n_err++;
      $display("FAIL nobypass_pre got %h/%h want aaaa/aaaa", bus0.op_a, bus0.op_b);
    end
    n_cmp++;
    if (bus1.op_a !== 16'h5555 || bus1.op_b !== 16'h5555) begin
      n_err++;
      $display("FAIL bypass_pre got %h/%h want 5555/5555", bus1.op_a, bus1.op_b);
    end
    bus0.sr2mux_sel = 1'b1;
    bus0.imm5       = 5'b00101;
    #1;
    n_cmp++;
    if (bus1.op_b !== 16'h0005 || bus1.op_a !== 16'h5555) begin
      n_err++;
      $display("FAIL bypass_imm got a=%h b=%h want 5555/0005", bus1.op_a, bus1.op_b);
    end
    bus0.sr2mux_sel = 1'b0;
    tick();
    bus0.ld_reg = 1'b0;
    #1;
    n_cmp++;
    if (bus0.op_a !== 16'h5555 || bus0.op_b !== 16'h5555 ||
        bus1.op_a !== 16'h5555 || bus1.op_b !== 16'h5555) begin
      n_err++;
      $display("FAIL bypass_post got %h %h %h %h want 5555", bus0.op_a, bus0.op_b, bus1.op_a, bus1.op_b);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    bus0.ld_reg  = 1'b1;
    bus0.ld_cc   = 1'b1;
    bus0.dr      = 3'd2;
    bus0.wr_data = 16'h1111;
    tick();
    bus0.wr_data = 16'hF222;
    tick();
    bus0.dr      = 3'd0;
    bus0.ld_cc   = 1'b0;
    bus0.wr_data = 16'h7FFF;
    tick();
    idle();
    bus0.sr1 = 3'd2;
    bus0.sr2 = 3'd0;
    #1;
    n_cmp++;
    if (bus0.op_a !== 16'hF222 || bus0.nzp !== 3'b100) begin
      n_err++;
      $display("FAIL b2b_last_wins got %h nzp=%b want f222/100", bus0.op_a, bus0.nzp);
    end
    n_cmp++;
    if (bus0.op_b !== 16'h7FFF || bus1.op_b !== 16'h7FFF) begin
      n_err++;
      $display("FAIL r0_writable got %h/%h want 7fff", bus0.op_b, bus1.op_b);
    end
  endtask

  task automatic test_rst_override();
    idle();
    bus0.ld_reg  = 1'b1;
    bus0.ld_cc   = 1'b1;
    bus0.dr      = 3'd7;
    bus0.wr_data = 16'hBEEF;
    rst          = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    bus0.sr1 = 3'd7;
    bus0.sr2 = 3'd5;
    #1;
    n_cmp++;
    if (bus0.op_a !== 16'h0000 || bus1.op_a !== 16'h0000 || bus0.op_b !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_override_regs got r7=%h/%h r5=%h want 0000", bus0.op_a, bus1.op_a, bus0.op_b);
    end
    n_cmp++;
    if (bus0.nzp !== 3'b010 || bus1.nzp !== 3'b010) begin
      n_err++;
      $display("FAIL rst_override_nzp got %b/%b want 010", bus0.nzp, bus1.nzp);
    end
  endtask

  task automatic test_random();
    logic [15:0] mregs [8];
    logic [2:0]  mnzp;
    logic [15:0] sext, exp_a0, exp_a1, exp_b0, exp_b1;
    int          bad;
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
    mnzp = 3'b010;
    bad  = 0;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      bus0.ld_reg     = 1'($urandom_range(0, 1));
      bus0.ld_cc      = 1'($urandom_range(0, 1));
      bus0.dr         = 3'($urandom_range(0, 7));
      bus0.sr1        = 3'($urandom_range(0, 7));
      bus0.sr2        = 3'($urandom_range(0, 7));
      bus0.imm5       = 5'($urandom_range(0, 31));
      bus0.sr2mux_sel = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       bus0.wr_data = 16'h0000;
        1:       bus0.wr_data = 16'h8000 | 16'($urandom);
        default: bus0.wr_data = 16'($urandom);
      endcase
      #1;
      sext   = {{11{bus0.imm5[4]}}, bus0.imm5};
      exp_a0 = mregs[bus0.sr1];
      exp_a1 = (bus0.ld_reg && bus0.dr == bus0.sr1) ? bus0.wr_data : mregs[bus0.sr1];
      exp_b0 = bus0.sr2mux_sel ? sext : mregs[bus0.sr2];
      exp_b1 = bus0.sr2mux_sel ? sext :
               ((bus0.ld_reg && bus0.dr == bus0.sr2) ? bus0.wr_data : mregs[bus0.sr2]);
      n_cmp++;
      if (bus0.op_a !== exp_a0 || bus0.op_b !== exp_b0 || bus0.nzp !== mnzp ||
          bus1.op_a !== exp_a1 || bus1.op_b !== exp_b1 || bus1.nzp !== mnzp) begin
        n_err++;
        bad++;
        if (bad <= 5)
          $display("FAIL random c%0d got a=%h/%h b=%h/%h nzp=%b/%b want a=%h/%h b=%h/%h nzp=%b",
                   c, bus0.op_a, bus1.op_a, bus0.op_b, bus1.op_b, bus0.nzp, bus1.nzp,
                   exp_a0, exp_a1, exp_b0, exp_b1, mnzp);
      end
      tick();
      if (bus0.ld_reg) mregs[bus0.dr] = bus0.wr_data;
      if (bus0.ld_cc)
        mnzp = bus0.wr_data[15] ? 3'b100 : ((bus0.wr_data == 16'h0000) ? 3'b010 : 3'b001);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_write();
    test_imm();
    test_nzp();
    test_bypass();
    test_back_to_back();
    test_rst_override();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
